// File: rtl/q01_pkg.sv
// Shared types and sizes for the 4-input truth-table sweep controller.
package q01_pkg;

  localparam int unsigned NUM_VEC = 16;
  localparam int unsigned VEC_W   = 4;
  localparam int unsigned SC_W    = 4;
  localparam int unsigned CNT_W   = 5;

  // Minterms 2,3,5,7,9,10,11,13 of F(A,B,C,D), A is MSB of the index.
  localparam logic [NUM_VEC-1:0] Q01_EXPECT = 16'h2EAC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CMP  = 2'd2
  } state_t;

endpackage : q01_pkg

// File: rtl/q01_first_diff.sv
// Lowest-set-bit encoder and popcount over the truth-table difference mask.
module q01_first_diff
  import q01_pkg::*;
(
  input  logic [NUM_VEC-1:0] diff,
  output logic [VEC_W-1:0]   first_idx_c,
  output logic [CNT_W-1:0]   count_c
);

  // Scan from the top so the lowest differing index is the last one written.
  always_comb begin
    first_idx_c = '0;
    count_c     = '0;
    for (int i = NUM_VEC - 1; i >= 0; i--) begin
      if (diff[i]) begin
        first_idx_c = VEC_W'(i);
      end
      count_c = count_c + CNT_W'(diff[i]);
    end
  end

endmodule : q01_first_diff

// File: rtl/q01_sweep_ctrl.sv
// Drives all 16 ABCD vectors into a combinational block, captures F per vector
// after a settle window, and grades the captured truth table against EXPECT.
module q01_sweep_ctrl
  import q01_pkg::*;
#(
  parameter int unsigned        SETTLE = 2,
  parameter logic [NUM_VEC-1:0] EXPECT = Q01_EXPECT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               f_in,
  output logic [VEC_W-1:0]   abcd,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [NUM_VEC-1:0] truth,
  output logic [VEC_W-1:0]   mismatch_idx,
  output logic [CNT_W-1:0]   mismatch_cnt
);

  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SETTLE);
  localparam logic [VEC_W-1:0] IDX_LAST = VEC_W'(NUM_VEC - 1);

  state_t            state;
  logic [SC_W-1:0]   sc;
  logic [VEC_W-1:0]  idx;

  logic [NUM_VEC-1:0] diff_c;
  logic [VEC_W-1:0]   first_idx_c;
  logic [CNT_W-1:0]   diff_cnt_c;

  assign diff_c = truth ^ EXPECT;

  q01_first_diff u_first_diff (
    .diff        (diff_c),
    .first_idx_c (first_idx_c),
    .count_c     (diff_cnt_c)
  );

  // Sequencer: abort beats start and every in-flight step; reset beats all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sc           <= '0;
      idx          <= '0;
      abcd         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      truth        <= '0;
      mismatch_idx <= '0;
      mismatch_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state        <= RUN;
            sc           <= '0;
            idx          <= '0;
            abcd         <= '0;
            busy         <= 1'b1;
            pass         <= 1'b0;
            truth        <= '0;
            mismatch_idx <= '0;
            mismatch_cnt <= '0;
          end
        end

        RUN: begin
          if (abort) begin
            state <= IDLE;
            abcd  <= '0;
            busy  <= 1'b0;
            pass  <= 1'b0;
          end else if (sc != SC_LAST) begin
            sc <= sc + SC_W'(1);
          end else begin
            sc         <= '0;
            truth[idx] <= f_in;
            if (idx == IDX_LAST) begin
              state <= CMP;
              abcd  <= '0;
            end else begin
              idx  <= idx + VEC_W'(1);
              abcd <= idx + VEC_W'(1);
            end
          end
        end

        CMP: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (abort) begin
            pass <= 1'b0;
          end else begin
            done         <= 1'b1;
            pass         <= (diff_c == '0);
            mismatch_idx <= first_idx_c;
            mismatch_cnt <= diff_cnt_c;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          abcd  <= '0;
        end
      endcase
    end
  end

endmodule : q01_sweep_ctrl

// File: tb/tb_q01_sweep_ctrl.sv
// Scoreboard bench for q01_sweep_ctrl: directed sweeps push expected results,
// a negedge monitor grades every done pulse.
module tb_q01_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        f_in;
  logic [3:0]  abcd;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] truth;
  logic [3:0]  mismatch_idx;
  logic [4:0]  mismatch_cnt;

  logic [15:0] model = 16'h2EAC;

  assign f_in = model[abcd];

  always #5 clk = ~clk;

  q01_sweep_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .f_in         (f_in),
    .abcd         (abcd),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .truth        (truth),
    .mismatch_idx (mismatch_idx),
    .mismatch_cnt (mismatch_cnt)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] truth;
    logic        pass;
    logic [3:0]  midx;
    logic [4:0]  mcnt;
    int          at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(sb.size()), 32'd1);
      end else begin
        mon_e = sb.pop_front();
        check("done_cycle",   32'(cyc),          32'(mon_e.at));
        check("truth",        32'(truth),        32'(mon_e.truth));
        check("pass",         32'(pass),         32'(mon_e.pass));
        check("mismatch_idx", 32'(mismatch_idx), 32'(mon_e.midx));
        check("mismatch_cnt", 32'(mismatch_cnt), 32'(mon_e.mcnt));
        check("busy_at_done", 32'(busy),         32'd0);
      end
    end
  end

  // Issues a start; returns k, the edge number that samples it.
  task automatic start_sweep(input logic [15:0] tbl, input logic exp_done,
                             input logic [15:0] e_truth, input logic e_pass,
                             input logic [3:0] e_midx, input logic [4:0] e_mcnt,
                             output int k);
    exp_t e;
    @(negedge clk);
    model = tbl;
    start = 1'b1;
    k = cyc + 1;
    if (exp_done) begin
      e.truth = e_truth;
      e.pass  = e_pass;
      e.midx  = e_midx;
      e.mcnt  = e_mcnt;
      e.at    = k + 49;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("sweep_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n;

    // Reset state
    #3;
    check("rst_abcd",  32'(abcd),  32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_pass",  32'(pass),  32'd0);
    check("rst_truth", 32'(truth), 32'd0);
    check("rst_midx",  32'(mismatch_idx), 32'd0);
    check("rst_mcnt",  32'(mismatch_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Matching model: check the vector stepping and busy window
    start_sweep(16'h2EAC, 1'b1, 16'h2EAC, 1'b1, 4'd0, 5'd0, k);
    for (int j = 0; j <= 48; j++) begin
      check("abcd_step", 32'(abcd), (j < 48) ? 32'(j / 3) : 32'd0);
      check("busy_run",  32'(busy), 32'd1);
      @(negedge clk);
    end
    wait_idle(100);

    // Index 6 stuck high
    start_sweep(16'h2EEC, 1'b1, 16'h2EEC, 1'b0, 4'd6, 5'd1, k);
    wait_idle(100);

    // F constant 0
    start_sweep(16'h0000, 1'b1, 16'h0000, 1'b0, 4'd2, 5'd8, k);
    wait_idle(100);

    // Start re-pulsed mid-sweep is ignored; exactly one done at k+49
    start_sweep(16'h2EAC, 1'b1, 16'h2EAC, 1'b1, 4'd0, 5'd0, k);
    while (cyc < k + 9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < k + 29) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(100);
    repeat (60) @(negedge clk);

    // Abort at edge k+20 while idx=6
    start_sweep(16'h2EAC, 1'b0, 16'h0, 1'b0, 4'd0, 5'd0, k);
    while (cyc < k + 19) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy",  32'(busy),  32'd0);
    check("abort_abcd",  32'(abcd),  32'd0);
    check("abort_pass",  32'(pass),  32'd0);
    check("abort_done",  32'(done),  32'd0);
    check("abort_truth", 32'(truth), 32'h002C);
    repeat (60) @(negedge clk);
    check("abort_truth_held", 32'(truth), 32'h002C);
    check("abort_idle_busy",  32'(busy),  32'd0);

    // start and abort together in IDLE: stays idle
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check("sa_busy_later", 32'(busy), 32'd0);
    check("sa_abcd",       32'(abcd), 32'd0);

    // Asynchronous reset at idx=9
    start_sweep(16'h2EAC, 1'b0, 16'h0, 1'b0, 4'd0, 5'd0, k);
    n = 0;
    while (abcd != 4'd9 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_idx9", 32'(abcd), 32'd9);
    check("busy_before_rst", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_abcd",  32'(abcd),  32'd0);
    check("arst_busy",  32'(busy),  32'd0);
    check("arst_done",  32'(done),  32'd0);
    check("arst_pass",  32'(pass),  32'd0);
    check("arst_truth", 32'(truth), 32'd0);
    check("arst_midx",  32'(mismatch_idx), 32'd0);
    check("arst_mcnt",  32'(mismatch_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_sweep(16'h2EAC, 1'b1, 16'h2EAC, 1'b1, 4'd0, 5'd0, k);
    wait_idle(100);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_q01_sweep_ctrl

// File: doc/q01_sweep_ctrl.md
# q01_sweep_ctrl

Sequencer that exhaustively exercises a 4-input combinational boolean block (inputs A, B, C, D; output F). On a start request it drives all 16 input vectors in ascending order and waits a programmable settle time per vector. It captures F into a 16-bit truth table and compares the result against an expected minterm mask. It sits between a test or configuration master and the combinational function block, owning the block's inputs for the duration of a sweep.

## Interface
Parameters:
- `SETTLE`, default 2: extra hold cycles per vector before sampling; legal range 0..15.
- `EXPECT`, default 16'h2EAC: expected truth table. Bit i = F for {A,B,C,D} = i, A is MSB. The default encodes minterms 2,3,5,7,9,10,11,13.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  sweep request; sampled only in IDLE.
- `abort`  in  1  synchronous abort; wins over everything except reset.
- `f_in`  in  1  F output of the combinational block.
- `abcd`  out  4  drive vector to the block: {A,B,C,D}.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  one-cycle pulse at sweep completion.
- `pass`  out  1  truth table equals EXPECT; held until next start.
- `truth`  out  16  captured truth table; held until next start.
- `mismatch_idx`  out  4  lowest index where truth ≠ EXPECT; 0 if pass.
- `mismatch_cnt`  out  5  number of differing bits, 0..16.

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: holds a sub-counter `sc` (0..SETTLE) and a vector index `idx` (0..15).
  - CMP: one-cycle comparison.
- IDLE→RUN on `start`:
  - `idx`=0, `sc`=0, `abcd`=0, `busy`=1.
  - Clears `truth`, `pass`, `mismatch_*`.
- RUN:
  - `abcd` = `idx`.
  - Each edge with `sc`<SETTLE increments `sc`.
  - On the edge with `sc`==SETTLE: `truth[idx]` ← `f_in`, `sc`←0.
  - If `idx`==15 at that edge: go to CMP and set `abcd`←0. Otherwise `idx`++.
  - `idx` never wraps.
- CMP→IDLE:
  - Registers `pass`, `mismatch_idx`, `mismatch_cnt` from `truth` XOR EXPECT.
  - `done`=1 for one cycle; `busy`=0.
- `start` in RUN/CMP is ignored; there is no queuing.
- `start` and `abort` together in IDLE: `abort` wins and the controller stays in IDLE.
- `abort` in RUN/CMP:
  - Next state is IDLE with `abcd`=0 and `busy`=0.
  - `done` is not pulsed and `pass`=0.
  - `truth` keeps the bits captured so far.
- Reset, including mid-sweep: immediate, asynchronous. All outputs go to 0: `abcd`, `busy`, `done`, `pass`, `truth`, `mismatch_idx`, `mismatch_cnt`. State goes to IDLE.

## Timing
- `start` sampled at edge k; `busy` rises after edge k.
- Vector i is driven for SETTLE+1 cycles and sampled at edge k+(i+1)(SETTLE+1).
- CMP is entered after edge k+16(SETTLE+1).
- `done`, `pass` and `mismatch_*` become valid after edge k+16(SETTLE+1)+1. At the same edge `busy` falls and `done` rises.
- Total latency from start to done is 16(SETTLE+1)+1 cycles. With SETTLE=2 that is 49 cycles.
- A new `start` is accepted in the cycle `done` is high, since the controller is already in IDLE.
- `f_in` must be valid SETTLE+1 cycles after `abcd` changes; this is the integrator's budget for the combinational path.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Package `q01_pkg` holds:
  - state enum {IDLE, RUN, CMP};
  - `NUM_VEC`=16;
  - `VEC_W`=4;
  - default expected mask `Q01_EXPECT`=16'h2EAC.
- Sub-module `q01_first_diff`: purely combinational lowest-set-bit encoder plus popcount over the 16-bit XOR. It feeds `mismatch_idx` and `mismatch_cnt`.
- Top level contains only the FSM, the counters and the capture register.

## Test plan
- Matching function model (F=1 for indices 2,3,5,7,9,10,11,13), SETTLE=2, start at edge 0:
  - `abcd` steps 0..15, each held 3 cycles;
  - `done` after edge 49;
  - `truth`=16'h2EAC, `pass`=1, `mismatch_cnt`=0.
- Model with index 6 forced to 1:
  - `truth`=16'h2EEC, `pass`=0;
  - `mismatch_idx`=6, `mismatch_cnt`=1.
- Model with F constant 0:
  - `truth`=0, `pass`=0;
  - `mismatch_idx`=2, `mismatch_cnt`=8.
- `start` re-pulsed at edges 10 and 30 during a sweep:
  - ignored;
  - `done` still occurs exactly once, after edge 49.
- `abort` at edge 20 (`idx`=6):
  - IDLE after edge 20, `abcd`=0, `busy`=0;
  - no `done`, `pass`=0;
  - `truth`[5:0] captured, upper bits 0.
- `rst_n` low mid-sweep at `idx`=9:
  - all outputs 0 immediately, without waiting for a clock edge;
  - after release, `start` runs a full clean sweep with `pass`=1.
